// File: rtl/kg_seq_2x2.sv
// kg_seq_2x2: sequential 2x2 Kalman gain K = P*H' * inv(H*P*H' + R).
// Define KG_SATURATE_EN for saturating rescales; overflow then sets err_singular.

module kg_seq_2x2 #(
  parameter int N     = 20,
  parameter int FRAC  = 10,
  parameter int ROUND = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] p00,
  input  logic signed [N-1:0] p01,
  input  logic signed [N-1:0] p10,
  input  logic signed [N-1:0] p11,
  input  logic signed [N-1:0] h00,
  input  logic signed [N-1:0] h01,
  input  logic signed [N-1:0] h10,
  input  logic signed [N-1:0] h11,
  input  logic signed [N-1:0] r00,
  input  logic signed [N-1:0] r01,
  input  logic signed [N-1:0] r10,
  input  logic signed [N-1:0] r11,
  output logic                busy,
  output logic                done,
  output logic                err_singular,
  output logic signed [N-1:0] K00,
  output logic signed [N-1:0] K01,
  output logic signed [N-1:0] K10,
  output logic signed [N-1:0] K11
);

  localparam int AW = 2*N+1;
  localparam int DW = N+FRAC;
  localparam int CW = $clog2(DW+1);
  localparam logic signed [AW:0] ONE = (AW+1)'(1);
  localparam logic signed [AW:0] HALF =
    (ROUND != 0) ? (ONE <<< (FRAC-1)) : '0;
`ifdef KG_SATURATE_EN
  localparam logic signed [AW:0] SMAX = (ONE <<< (N-1)) - ONE;
  localparam logic signed [AW:0] SMIN = -SMAX - ONE;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PHT, S_HS, S_DET,
    S_DIV, S_KADJ, S_KSCL, S_DONE
  } st_t;

  st_t st_q, st_d;
  logic [CW-1:0] cnt;

  logic signed [N-1:0] p [4];
  logic signed [N-1:0] h [4];
  logic signed [N-1:0] r [4];
  logic signed [N-1:0] a [4];
  logic signed [N-1:0] s [4];
  logic signed [N-1:0] b [4];
  logic signed [N-1:0] kq [4];

  logic signed [AW-1:0] acc, det;
  logic [AW-1:0] dmag, rem, mag;
  logic [DW-1:0] q;
  logic qhi, dneg, ovf;

  logic [1:0] e;
  logic t, sub, ge;
  logic signed [N-1:0] x, y, recip;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0] base, sum, radd, tot;
  logic [N:0] rs_o, rc_o;
  logic signed [AW:0] qs;
  logic [AW:0] rsh, rdif;

  // returns {overflow, value}
  function automatic logic [N:0] fit(input logic signed [AW:0] v);
`ifdef KG_SATURATE_EN
    if (v > SMAX)
      fit = {1'b1, SMAX[N-1:0]};
    else if (v < SMIN)
      fit = {1'b1, SMIN[N-1:0]};
    else
      fit = {1'b0, v[N-1:0]};
`else
    fit = {1'b0, v[N-1:0]};
`endif
  endfunction

  function automatic logic [N:0] rescale(
    input logic signed [AW-1:0] v
  );
    logic signed [AW:0] w;
    w = (AW+1)'(v) + HALF;
    rescale = fit(w >>> FRAC);
  endfunction

  function automatic logic run(input st_t st);
    run = (st != S_IDLE) && (st != S_DONE);
  endfunction

  assign e = cnt[2:1];
  assign t = cnt[0];
  assign prod = x * y;
  assign done = (st_q == S_DONE);

  assign K00 = kq[0];
  assign K01 = kq[1];
  assign K10 = kq[2];
  assign K11 = kq[3];

  always_comb begin
    x   = '0;
    y   = '0;
    sub = 1'b0;
    unique case (st_q)
      S_PHT: begin
        x = p[{e[1], t}];
        y = h[{e[0], t}];
      end
      S_HS: begin
        x = h[{e[1], t}];
        y = a[{t, e[0]}];
      end
      S_DET: begin
        x   = t ? s[1] : s[0];
        y   = t ? s[2] : s[3];
        sub = t;
      end
      // adj(S) = [s11 -s01; -s10 s00]
      S_KADJ: begin
        x   = a[{e[1], t}];
        y   = s[{~e[0], ~t}];
        sub = t ^ e[0];
      end
      S_KSCL: begin
        x = b[cnt[1:0]];
        y = recip;
      end
      default: ;
    endcase
  end

  always_comb begin
    base = (st_q == S_KSCL || !t) ? '0 : acc;
    sum  = sub ? base - AW'(prod)
               : base + AW'(prod);
    radd = '0;
    if (st_q == S_HS)
      radd = AW'(r[e]) <<< FRAC;
    tot  = sum + radd;
    rs_o = rescale(tot);
    mag  = sum[AW-1] ? $unsigned(-sum)
                     : $unsigned(sum);
  end

  always_comb begin
    qs = (AW+1)'({qhi, q});
    if (dneg)
      qs = -qs;
    rc_o  = fit(qs);
    recip = rc_o[N-1:0];
    rsh   = {rem, 1'b0};
    rdif  = rsh - {1'b0, dmag};
    ge    = rsh >= {1'b0, dmag};
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: if (start) st_d = S_PHT;
      S_PHT:  if (cnt == CW'(7)) st_d = S_HS;
      S_HS:   if (cnt == CW'(7)) st_d = S_DET;
      S_DET:  if (cnt == CW'(1)) st_d = S_DIV;
      S_DIV: begin
        if (det == '0)
          st_d = S_DONE;
        else if (cnt == CW'(DW-1))
          st_d = S_KADJ;
      end
      S_KADJ: if (cnt == CW'(7)) st_d = S_KSCL;
      S_KSCL: if (cnt == CW'(3)) st_d = S_DONE;
      S_DONE: st_d = start ? S_PHT : S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_IDLE;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q || st_q == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      busy <= run(st_q) && run(st_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        p[i]  <= '0;
        h[i]  <= '0;
        r[i]  <= '0;
        a[i]  <= '0;
        s[i]  <= '0;
        b[i]  <= '0;
        kq[i] <= '0;
      end
      acc          <= '0;
      det          <= '0;
      dmag         <= '0;
      rem          <= '0;
      q            <= '0;
      qhi          <= 1'b0;
      dneg         <= 1'b0;
      ovf          <= 1'b0;
      err_singular <= 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            p[0] <= p00; p[1] <= p01;
            p[2] <= p10; p[3] <= p11;
            h[0] <= h00; h[1] <= h01;
            h[2] <= h10; h[3] <= h11;
            r[0] <= r00; r[1] <= r01;
            r[2] <= r10; r[3] <= r11;
            ovf          <= 1'b0;
            err_singular <= 1'b0;
          end
        end
        S_PHT: begin
          if (t) begin
            a[e] <= rs_o[N-1:0];
            ovf  <= ovf | rs_o[N];
          end else begin
            acc <= sum;
          end
        end
        S_HS: begin
          if (t) begin
            s[e] <= rs_o[N-1:0];
            ovf  <= ovf | rs_o[N];
          end else begin
            acc <= sum;
          end
        end
        S_DET: begin
          if (t) begin
            det  <= sum;
            dneg <= sum[AW-1];
            dmag <= mag;
            // |det|==1 is the only case with quotient bit DW set
            qhi  <= (mag == AW'(1));
            rem  <= (mag == AW'(1)) ? '0 : AW'(1);
            q    <= '0;
          end else begin
            acc <= sum;
          end
        end
        S_DIV: begin
          if (det == '0) begin
            for (int i = 0; i < 4; i++)
              kq[i] <= '0;
            err_singular <= 1'b1;
          end else begin
            q   <= {q[DW-2:0], ge};
            rem <= ge ? rdif[AW-1:0] : rsh[AW-1:0];
          end
        end
        S_KADJ: begin
          if (t) begin
            b[e] <= rs_o[N-1:0];
            ovf  <= ovf | rs_o[N];
          end else begin
            acc <= sum;
          end
        end
        S_KSCL: begin
          b[cnt[1:0]] <= rs_o[N-1:0];
          if (cnt[1:0] == 2'd3) begin
            kq[0] <= b[0];
            kq[1] <= b[1];
            kq[2] <= b[2];
            kq[3] <= rs_o[N-1:0];
            err_singular <= ovf | rs_o[N] | rc_o[N];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kg_seq_2x2.sv
// tb_kg_seq_2x2: directed and random runs of kg_seq_2x2 against a matrix-level model.
// Build with KG_SATURATE_EN to check the saturating variant.

module tb_kg_seq_2x2;

  localparam int NB = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [NB-1:0] mi [12];
  logic busy, done, err;
  logic signed [NB-1:0] k00, k01, k10, k11;

  int total = 0;
  int bad = 0;

  longint pin [12];
  longint ek [4];
  logic ee;
  int el;
  logic movf;

  always #5 clk = ~clk;

  kg_seq_2x2 dut (
    .clk(clk), .rst(rst), .start(start),
    .p00(mi[0]), .p01(mi[1]), .p10(mi[2]), .p11(mi[3]),
    .h00(mi[4]), .h01(mi[5]), .h10(mi[6]), .h11(mi[7]),
    .r00(mi[8]), .r01(mi[9]), .r10(mi[10]), .r11(mi[11]),
    .busy(busy), .done(done), .err_singular(err),
    .K00(k00), .K01(k01), .K10(k10), .K11(k11)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint fitm(input longint v);
    longint m;
    m = 64'sd1 <<< (NB-1);
`ifdef KG_SATURATE_EN
    if (v > m - 1) begin
      movf = 1'b1;
      return m - 1;
    end
    if (v < -m) begin
      movf = 1'b1;
      return -m;
    end
    return v;
`else
    begin
      longint w;
      w = v & ((m <<< 1) - 1);
      if (w >= m)
        w = w - (m <<< 1);
      return w;
    end
`endif
  endfunction

  function automatic longint rsc(input longint v);
    return fitm((v + 512) >>> 10);
  endfunction

  // K = P*H' * adj(S) * (1/det), each product rescaled once
  task automatic model();
    longint am [4];
    longint sm [4];
    longint adj [4];
    longint bm [4];
    longint dt, rc;
    movf = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        am[i*2+j] = rsc(pin[i*2]*pin[4+j*2]
                      + pin[i*2+1]*pin[4+j*2+1]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        sm[i*2+j] = rsc(pin[4+i*2]*am[j]
                      + pin[4+i*2+1]*am[2+j]
                      + (pin[8+i*2+j] <<< 10));
    dt = sm[0]*sm[3] - sm[1]*sm[2];
    if (dt == 0) begin
      for (int i = 0; i < 4; i++)
        ek[i] = 0;
      ee = 1'b1;
      el = 19;
      return;
    end
    rc = fitm((64'sd1 <<< 30) / dt);
    adj[0] = sm[3];
    adj[1] = -sm[1];
    adj[2] = -sm[2];
    adj[3] = sm[0];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        bm[i*2+j] = rsc(am[i*2]*adj[j]
                      + am[i*2+1]*adj[2+j]);
    for (int i = 0; i < 4; i++)
      ek[i] = rsc(bm[i]*rc);
    ee = movf;
    el = 60;
  endtask

  task automatic setp(
    input longint a0, a1, a2, a3,
    input longint b0, b1, b2, b3,
    input longint c0, c1, c2, c3);
    pin[0] = a0; pin[1] = a1; pin[2] = a2; pin[3] = a3;
    pin[4] = b0; pin[5] = b1; pin[6] = b2; pin[7] = b3;
    pin[8] = c0; pin[9] = c1; pin[10] = c2; pin[11] = c3;
  endtask

  function automatic longint rsmall();
    return longint'($urandom_range(0, 4096)) - 2048;
  endfunction

  function automatic longint rfull();
    logic [NB-1:0] v;
    v = NB'($urandom);
    return longint'($signed(v));
  endfunction

  task automatic drive_in();
    for (int k = 0; k < 12; k++)
      mi[k] = NB'(pin[k]);
  endtask

  task automatic launch();
    @(negedge clk);
    drive_in();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy && !done)
        nb++;
    end
  endtask

  task automatic chk_k(input string tag);
    chk({tag, "_k00"}, k00, ek[0]);
    chk({tag, "_k01"}, k01, ek[1]);
    chk({tag, "_k10"}, k10, ek[2]);
    chk({tag, "_k11"}, k11, ek[3]);
    chk({tag, "_err"}, err, ee);
  endtask

  task automatic check_run(input string tag);
    int lat, nb;
    model();
    launch();
    wait_done(lat, nb);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_busy"}, nb, el - 1);
    chk({tag, "_bdone"}, busy, 0);
    chk_k(tag);
  endtask

  initial begin
    int lat, nb, nd;
    for (int k = 0; k < 12; k++)
      mi[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_k00", k00, 0);
    chk("rst_k11", k11, 0);

    setp(1024, 0, 0, 1024, 1024, 0, 0, 1024,
         256, 0, 0, 256);
    check_run("ident");
    chk("ident_k00c", k00, 819);
    chk("ident_k01c", k01, 0);

    setp(2048, 512, 512, 1024, 1024, 0, 0, 1024,
         1024, 0, 0, 1024);
    check_run("cov2");
    chk("cov2_k00c", k00, 668);
    chk("cov2_k01c", k01, 89);
    chk("cov2_k11c", k11, 490);

    setp(0, 0, 0, 0, 1024, 0, 0, 1024, 0, 0, 0, 0);
    check_run("sing");
    chk("sing_errc", err, 1);
    setp(1024, 0, 0, 1024, 1024, 0, 0, 1024,
         256, 0, 0, 256);
    check_run("clr");
    chk("clr_errc", err, 0);

    // start while busy is ignored; then back-to-back from DONE
    for (int k = 0; k < 12; k++)
      pin[k] = rsmall();
    model();
    launch();
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 9) begin
        start = 1'b1;
        for (int k = 0; k < 12; k++)
          mi[k] = NB'(rsmall());
      end
      if (lat == 10)
        start = 1'b0;
    end
    chk("ign_lat", lat, 60);
    chk_k("ign");
    for (int k = 0; k < 12; k++)
      pin[k] = rsmall();
    model();
    drive_in();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept", done, 0);
    wait_done(lat, nb);
    chk("b2b_lat", lat, 60);
    chk("b2b_busy", nb, 59);
    chk_k("b2b");
    nd = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done)
        nd++;
    end
    chk("no_queue", nd, 0);

    // asynchronous reset mid-run
    for (int k = 0; k < 12; k++)
      pin[k] = rsmall();
    launch();
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_k00", k00, 0);
    chk("arst_k11", k11, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done)
        nd++;
    end
    chk("arst_nodone", nd, 0);
    setp(2048, 512, 512, 1024, 1024, 0, 0, 1024,
         1024, 0, 0, 1024);
    check_run("post_rst");

    setp(307200, 0, 0, 307200, 2048, 0, 0, 2048,
         256, 0, 0, 256);
    check_run("big");
`ifdef KG_SATURATE_EN
    chk("big_errc", err, 1);
`else
    chk("big_errc", err, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 12; k++)
        pin[k] = (n % 3 == 2) ? rfull() : rsmall();
      if (n % 3 == 1)
        for (int k = 4; k < 8; k++)
          pin[k] = (k == 4 || k == 7) ? 1024 : 0;
      check_run("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
